// File: rtl/vram_arbiter.sv
// Shares the PPU video RAM between the rendering fetch unit and CPU PPUDATA accesses.
// Optional palette mirroring is enabled by defining VRAM_ARB_PAL_MIRROR_EN.
module vram_arbiter #(
    parameter int unsigned STARVE_MAX = 7,
    parameter int unsigned STARVE_W   = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ren_req,
    input  logic [13:0] ren_addr,
    output logic        ren_stall,
    output logic        ren_valid,
    output logic [7:0]  ren_data,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [13:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_busy,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    output logic        ram_we,
    output logic [15:0] ram_w_addr,
    output logic [7:0]  ram_w_data,
    output logic [13:0] ram_r_addr,
    input  logic [7:0]  ram_r_data
);

    typedef enum logic [1:0] {StIdle, StPend, StAck} state_e;

    localparam logic [STARVE_W-1:0] StarveMax = STARVE_W'(STARVE_MAX);

    state_e              state_q, state_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                lat_we_q, lat_we_d;
    logic [13:0]         lat_addr_q, lat_addr_d;
    logic [7:0]          lat_wdata_q, lat_wdata_d;
    logic                ren_valid_q;
    logic [7:0]          ren_data_q;
    logic [7:0]          cpu_rdata_q;
    logic                grant;
    logic                cpu_slot;
    logic                ren_take;

    // Palette entries 0x10/14/18/1C alias the backdrop entries 0x00/04/08/0C.
    function automatic logic [13:0] pal_map(input logic [13:0] a);
        logic [13:0] r;
        r = a;
`ifdef VRAM_ARB_PAL_MIRROR_EN
        if (a[13:8] == 6'h3F && a[1:0] == 2'b00) begin
            r[4] = 1'b0;
        end
`endif
        return r;
    endfunction

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        lat_we_d    = lat_we_q;
        lat_addr_d  = lat_addr_q;
        lat_wdata_d = lat_wdata_q;
        grant       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cpu_req) begin
                    state_d     = StPend;
                    lat_we_d    = cpu_we;
                    lat_addr_d  = cpu_addr;
                    lat_wdata_d = cpu_wdata;
                end
            end
            StPend: begin
                if (!ren_req || starve_q == StarveMax) begin
                    grant    = 1'b1;
                    state_d  = StAck;
                    starve_d = '0;
                end else if (starve_q != StarveMax) begin
                    starve_d = starve_q + 1'b1;
                end
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Gating with reset keeps the RAM and renderer untouched while reset is held.
    always_comb begin
        cpu_slot   = grant & reset;
        ren_stall  = ren_req & cpu_slot;
        ren_take   = ren_req & ~ren_stall;
        ram_we     = cpu_slot & lat_we_q;
        ram_w_addr = {2'b00, pal_map(lat_addr_q)};
        ram_w_data = lat_wdata_q;
        ram_r_addr = (cpu_slot && !lat_we_q) ? pal_map(lat_addr_q) : pal_map(ren_addr);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= StIdle;
            starve_q    <= '0;
            lat_we_q    <= 1'b0;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
            ren_valid_q <= 1'b0;
            ren_data_q  <= '0;
            cpu_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            lat_we_q    <= lat_we_d;
            lat_addr_q  <= lat_addr_d;
            lat_wdata_q <= lat_wdata_d;
            ren_valid_q <= ren_take;
            if (ren_take) begin
                ren_data_q <= ram_r_data;
            end
            if (cpu_slot && !lat_we_q) begin
                cpu_rdata_q <= ram_r_data;
            end
        end
    end

    assign ren_valid = ren_valid_q;
    assign ren_data  = ren_data_q;
    assign cpu_rdata = cpu_rdata_q;
    assign cpu_busy  = (state_q != StIdle);
    assign cpu_ack   = (state_q == StAck);

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: driver pushes expected responses, a negedge monitor pops them.
// A second instance covers STARVE_MAX=0.
module tb_vram_arbiter;

    typedef struct packed {
        logic       is_read;
        logic [7:0] data;
    } cpu_exp_t;

    logic        clock;
    logic        reset;
    logic        ren_req;
    logic [13:0] ren_addr;
    logic        ren_stall;
    logic        ren_valid;
    logic [7:0]  ren_data;
    logic        cpu_req;
    logic        cpu_we;
    logic [13:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_busy;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic        ram_we;
    logic [15:0] ram_w_addr;
    logic [7:0]  ram_w_data;
    logic [13:0] ram_r_addr;
    logic [7:0]  ram_r_data;

    logic        ren_req1;
    logic [13:0] ren_addr1;
    logic        ren_stall1;
    logic        ren_valid1;
    logic [7:0]  ren_data1;
    logic        cpu_req1;
    logic        cpu_we1;
    logic [13:0] cpu_addr1;
    logic [7:0]  cpu_wdata1;
    logic        cpu_busy1;
    logic        cpu_ack1;
    logic [7:0]  cpu_rdata1;
    logic        ram_we1;
    logic [15:0] ram_w_addr1;
    logic [7:0]  ram_w_data1;
    logic [13:0] ram_r_addr1;
    logic [7:0]  ram_r_data1;

    logic [7:0]  mem0    [0:16383];
    logic [7:0]  mem1    [0:16383];
    logic [7:0]  ref_mem [0:16383];

    logic [7:0]  ren_q [$];
    cpu_exp_t    cpu_q [$];
    logic [13:0] lat_addr;
    logic [7:0]  lat_wdata;
    int          errors;
    int          checks;

    vram_arbiter #(.STARVE_MAX(7), .STARVE_W(4)) dut (
        .clock(clock), .reset(reset),
        .ren_req(ren_req), .ren_addr(ren_addr), .ren_stall(ren_stall),
        .ren_valid(ren_valid), .ren_data(ren_data),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_busy(cpu_busy), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .ram_we(ram_we), .ram_w_addr(ram_w_addr), .ram_w_data(ram_w_data),
        .ram_r_addr(ram_r_addr), .ram_r_data(ram_r_data)
    );

    vram_arbiter #(.STARVE_MAX(0), .STARVE_W(4)) dut0 (
        .clock(clock), .reset(reset),
        .ren_req(ren_req1), .ren_addr(ren_addr1), .ren_stall(ren_stall1),
        .ren_valid(ren_valid1), .ren_data(ren_data1),
        .cpu_req(cpu_req1), .cpu_we(cpu_we1), .cpu_addr(cpu_addr1), .cpu_wdata(cpu_wdata1),
        .cpu_busy(cpu_busy1), .cpu_ack(cpu_ack1), .cpu_rdata(cpu_rdata1),
        .ram_we(ram_we1), .ram_w_addr(ram_w_addr1), .ram_w_data(ram_w_data1),
        .ram_r_addr(ram_r_addr1), .ram_r_data(ram_r_data1)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [7:0] initv(input int a);
        return 8'(a ^ (a >> 7));
    endfunction

    function automatic logic [13:0] pmap(input logic [13:0] a);
        logic [13:0] r;
        r = a;
`ifdef VRAM_ARB_PAL_MIRROR_EN
        if (a[13:8] == 6'h3F && a[1:0] == 2'b00) begin
            r[4] = 1'b0;
        end
`endif
        return r;
    endfunction

    // RAM models: synchronous write, combinational read
    initial begin
        for (int i = 0; i < 16384; i++) begin
            mem0[i] <= initv(i);
            mem1[i] <= initv(i);
        end
    end

    always @(posedge clock) begin
        if (ram_we) mem0[ram_w_addr[13:0]] <= ram_w_data;
        if (ram_we1) mem1[ram_w_addr1[13:0]] <= ram_w_data1;
    end

    assign ram_r_data  = mem0[ram_r_addr];
    assign ram_r_data1 = mem1[ram_r_addr1];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: ren_valid must appear exactly one cycle after each pushed rendering read.
    always @(negedge clock) begin
        if (ren_valid === 1'b1) begin
            if (ren_q.size() == 0) begin
                chk("ren_valid_unexpected", 16'(ren_valid), 16'h0);
            end else begin
                chk("ren_data", 16'(ren_data), 16'(ren_q.pop_front()));
            end
        end else if (ren_q.size() != 0) begin
            chk("ren_valid_missing", 16'(ren_valid), 16'h1);
            void'(ren_q.pop_front());
        end
        if (cpu_ack === 1'b1) begin
            if (cpu_q.size() == 0) begin
                chk("cpu_ack_unexpected", 16'(cpu_ack), 16'h0);
            end else begin
                cpu_exp_t e;
                e = cpu_q.pop_front();
                if (e.is_read) chk("cpu_rdata", 16'(cpu_rdata), 16'(e.data));
            end
        end
    end

    // One cycle of stimulus on the main instance with the expected combinational behaviour.
    task automatic step(input logic rreq, input logic [13:0] raddr,
                        input logic creq, input logic cwe, input logic [13:0] caddr,
                        input logic [7:0] cwd,
                        input logic x_stall, input logic x_we, input logic x_ack);
        ren_req   = rreq;
        ren_addr  = raddr;
        cpu_req   = creq;
        cpu_we    = cwe;
        cpu_addr  = caddr;
        cpu_wdata = cwd;
        if (creq && reset) begin
            lat_addr  = caddr;
            lat_wdata = cwd;
            cpu_q.push_back('{is_read: !cwe, data: ref_mem[pmap(caddr)]});
        end
        @(negedge clock);
        chk("ren_stall", 16'(ren_stall), 16'(x_stall));
        chk("ram_we", 16'(ram_we), 16'(x_we));
        chk("cpu_ack", 16'(cpu_ack), 16'(x_ack));
        if (x_we) begin
            chk("ram_w_addr", ram_w_addr, {2'b00, pmap(lat_addr)});
            chk("ram_w_data", 16'(ram_w_data), 16'(lat_wdata));
            ref_mem[pmap(lat_addr)] = lat_wdata;
        end
        @(posedge clock);
        #1;
        if (rreq && !x_stall && reset) ren_q.push_back(ref_mem[pmap(raddr)]);
    endtask

    task automatic idle();
        step(1'b0, 14'h0, 1'b0, 1'b0, 14'h0, 8'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        lat_addr = '0;
        lat_wdata = '0;
        for (int i = 0; i < 16384; i++) ref_mem[i] = initv(i);
        reset = 1'b0;
        ren_req = 1'b0; ren_addr = '0; cpu_req = 1'b0; cpu_we = 1'b0;
        cpu_addr = '0; cpu_wdata = '0;
        ren_req1 = 1'b0; ren_addr1 = '0; cpu_req1 = 1'b0; cpu_we1 = 1'b0;
        cpu_addr1 = '0; cpu_wdata1 = '0;
        @(posedge clock);
        #1;

        // Reset held with both requesters active
        step(1'b1, 14'h0100, 1'b1, 1'b1, 14'h0100, 8'h77, 1'b0, 1'b0, 1'b0);
        step(1'b1, 14'h0100, 1'b1, 1'b1, 14'h0100, 8'h77, 1'b0, 1'b0, 1'b0);
        chk("rst_ren_valid", 16'(ren_valid), 16'h0);
        chk("rst_ren_data", 16'(ren_data), 16'h0);
        chk("rst_cpu_rdata", 16'(cpu_rdata), 16'h0);
        chk("rst_cpu_busy", 16'(cpu_busy), 16'h0);
        reset = 1'b1;
        step(1'b1, 14'h0100, 1'b0, 1'b0, 14'h0, 8'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 14'h0101, 1'b0, 1'b0, 14'h0, 8'h0, 1'b0, 1'b0, 1'b0);
        idle();

        // Idle-slot CPU write then read back
        step(1'b0, 14'h0, 1'b1, 1'b1, 14'h2000, 8'hA5, 1'b0, 1'b0, 1'b0);
        chk("busy_c1", 16'(cpu_busy), 16'h1);
        step(1'b0, 14'h0, 1'b0, 1'b0, 14'h0, 8'h0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 14'h0, 1'b0, 1'b0, 14'h0, 8'h0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 14'h0, 1'b1, 1'b0, 14'h2000, 8'h0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 14'h0, 1'b0, 1'b0, 14'h0, 8'h0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 14'h0, 1'b0, 1'b0, 14'h0, 8'h0, 1'b0, 1'b0, 1'b1);
        idle();

        // Starvation: continuous rendering, CPU read forced through in PEND cycle 8
        step(1'b1, 14'h0200, 1'b1, 1'b0, 14'h0300, 8'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 7; i++) begin
            step(1'b1, 14'h0200, 1'b0, 1'b0, 14'h0, 8'h0, 1'b0, 1'b0, 1'b0);
        end
        step(1'b1, 14'h0200, 1'b0, 1'b0, 14'h0, 8'h0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 14'h0200, 1'b0, 1'b0, 14'h0, 8'h0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 14'h0201, 1'b0, 1'b0, 14'h0, 8'h0, 1'b0, 1'b0, 1'b0);
        idle();

        // Same address: stalled rendering read retries and sees the CPU write
        step(1'b1, 14'h23C0, 1'b1, 1'b1, 14'h23C0, 8'h5A, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 7; i++) begin
            step(1'b1, 14'h23C0, 1'b0, 1'b0, 14'h0, 8'h0, 1'b0, 1'b0, 1'b0);
        end
        step(1'b1, 14'h23C0, 1'b0, 1'b0, 14'h0, 8'h0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 14'h23C0, 1'b0, 1'b0, 14'h0, 8'h0, 1'b0, 1'b0, 1'b1);
        idle();

        // Palette mirror: write 0x3F10, render-read 0x3F00
        step(1'b0, 14'h0, 1'b1, 1'b1, 14'h3F10, 8'h11, 1'b0, 1'b0, 1'b0);
        step(1'b0, 14'h0, 1'b0, 1'b0, 14'h0, 8'h0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 14'h0, 1'b0, 1'b0, 14'h0, 8'h0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 14'h3F00, 1'b0, 1'b0, 14'h0, 8'h0, 1'b0, 1'b0, 1'b0);
        idle();
        idle();

        // STARVE_MAX=0 instance: CPU wins the first PEND cycle
        ren_req1 = 1'b1; ren_addr1 = 14'h0040;
        cpu_req1 = 1'b1; cpu_we1 = 1'b0; cpu_addr1 = 14'h0005;
        @(negedge clock);
        chk("s0_stall_c0", 16'(ren_stall1), 16'h0);
        @(posedge clock);
        #1;
        cpu_req1 = 1'b0;
        @(negedge clock);
        chk("s0_stall_c1", 16'(ren_stall1), 16'h1);
        chk("s0_r_addr_c1", 16'(ram_r_addr1), 16'h0005);
        chk("s0_busy_c1", 16'(cpu_busy1), 16'h1);
        chk("s0_ren_valid_c1", 16'(ren_valid1), 16'h1);
        chk("s0_ren_data_c1", 16'(ren_data1), 16'h40);
        @(posedge clock);
        #1;
        @(negedge clock);
        chk("s0_ack_c2", 16'(cpu_ack1), 16'h1);
        chk("s0_rdata_c2", 16'(cpu_rdata1), 16'h05);
        chk("s0_stall_c2", 16'(ren_stall1), 16'h0);
        chk("s0_ren_valid_c2", 16'(ren_valid1), 16'h0);
        @(posedge clock);
        #1;
        ren_req1 = 1'b0;
        idle();

        chk("ren_q_drained", 16'(ren_q.size()), 16'h0);
        chk("cpu_q_drained", 16'(cpu_q.size()), 16'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
